// File: rtl/fuzz_exec_core.sv
// fuzz_exec_core: multi-cycle fuzz ISA core with mu accounting and a sequential 256-bit state hash.
// Define FUZZ_CORE_TRACE_EN to add the per-instruction trace_valid/trace_data port.
module fuzz_exec_core #(
  parameter int IMEM_AW     = 8,
  parameter int DMEM_AW     = 4,
  parameter int MAX_MODULES = 64,
  parameter int MASK_W      = 64,
  parameter int MU_W        = 64,
  parameter int TIMEOUT     = 10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_wdata,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               halted_ok,
  output logic               timeout,
  output logic [255:0]       final_hash,
  output logic [MU_W-1:0]    mu_total,
  output logic [MU_W-1:0]    mu_discovery,
  output logic [MU_W-1:0]    mu_execution,
  output logic [31:0]        step_count,
  output logic [31:0]        num_modules,
  output logic [31:0]        pc_out
`ifdef FUZZ_CORE_TRACE_EN
  ,
  output logic               trace_valid,
  output logic [63:0]        trace_data
`endif
);
  localparam int MIW = MAX_MODULES > 1 ? $clog2(MAX_MODULES) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, SWAP2, SWAP3, HASH, DONE} state_t;
  state_t state;
  logic [31:0] imem [2**IMEM_AW];
  logic [31:0] dmem [2**DMEM_AW];
  logic [MASK_W-1:0] mask [MAX_MODULES];
  logic [31:0] ir, next_id, icnt, hw;
  logic [2:0] hidx;
  logic [7:0] op, mod_a;
  logic [DMEM_AW-1:0] ia, ib;
  logic last, unused_lo;
  assign op = ir[31:24];
  assign ia = ir[16 +: DMEM_AW];
  assign ib = ir[8 +: DMEM_AW];
  assign mod_a = 8'(32'(ir[23:16]) % MASK_W);
  assign last = icnt + 32'd1 == 32'(TIMEOUT);
  assign unused_lo = ^ir[7:0];
  function automatic logic [31:0] mix(input logic [31:0] v);
    logic [31:0] x;
    x = v ^ (v << 13);
    x = x ^ (x >> 17);
    return x ^ (x << 5);
  endfunction
  always_comb begin
    hw = 32'h0;
    case (hidx)
      3'd0: hw = pc_out ^ next_id;
      3'd1: hw = num_modules ^ step_count;
      3'd2: hw = 32'(mu_discovery) ^ 32'(mu_execution);
      3'd3: hw = 32'(mu_total);
      3'd4: hw = 32'(mask[0]);
      3'd5: hw = 32'(mask[1]);
      3'd6: hw = dmem[0];
      default: hw = dmem[1];
    endcase
  end
  always_ff @(posedge clk) begin
    if (imem_we && !busy) imem[imem_addr] <= imem_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || ((state == IDLE || state == DONE) && start)) begin
      state <= rst_n ? FETCH : IDLE;
      busy <= rst_n;
      done <= 1'b0;
      halted_ok <= 1'b0;
      timeout <= 1'b0;
      final_hash <= '0;
      mu_total <= '0;
      mu_discovery <= '0;
      mu_execution <= '0;
      step_count <= '0;
      num_modules <= '0;
      pc_out <= '0;
      next_id <= '0;
      icnt <= '0;
      hidx <= '0;
      ir <= '0;
      for (int i = 0; i < 2**DMEM_AW; i++) dmem[i] <= '0;
      for (int i = 0; i < MAX_MODULES; i++) mask[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir <= imem[pc_out[IMEM_AW-1:0]];
          state <= EXEC;
        end
        EXEC: if (op == 8'hFF) begin
          mu_total <= mu_discovery + mu_execution;
          halted_ok <= 1'b1;
          hidx <= '0;
          state <= HASH;
        end else begin
          pc_out <= pc_out + 32'd1;
          step_count <= step_count + 32'd1;
          icnt <= icnt + 32'd1;
          if (op == 8'h00 && num_modules < 32'(MAX_MODULES)) begin
            mask[num_modules[MIW-1:0]] <= MASK_W'(1) << mod_a;
            next_id <= next_id + 32'd1;
            num_modules <= num_modules + 32'd1;
            mu_discovery <= mu_discovery + MU_W'(1);
          end
          if (op == 8'h0A) dmem[ia] <= 32'(ir[15:8]);
          if (op == 8'h0B || op == 8'h0C) dmem[ia] <= dmem[ia] ^ dmem[ib];
          if (op == 8'h0A || op == 8'h0B) mu_execution <= mu_execution + MU_W'(1);
          if (op == 8'h0C) mu_execution <= mu_execution + MU_W'(3);
          // A swap finishes its three XORs before the budget abort is honoured.
          state <= op == 8'h0C ? SWAP2 : last ? DONE : FETCH;
          if (op != 8'h0C && last) begin
            timeout <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        SWAP2: begin
          dmem[ib] <= dmem[ib] ^ dmem[ia];
          state <= SWAP3;
        end
        SWAP3: begin
          dmem[ia] <= dmem[ia] ^ dmem[ib];
          state <= icnt == 32'(TIMEOUT) ? DONE : FETCH;
          if (icnt == 32'(TIMEOUT)) begin
            timeout <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        HASH: begin
          final_hash[{hidx, 5'd0} +: 32] <= mix(hw);
          hidx <= hidx + 3'd1;
          if (hidx == 3'd7) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        IDLE, DONE: state <= state;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FUZZ_CORE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_data <= '0;
    end else begin
      trace_valid <= state == EXEC;
      if (state == EXEC) trace_data <= {pc_out[15:0], ir[31:8], step_count[15:0], 8'h0};
    end
  end
`endif
endmodule

// File: tb/tb_fuzz_exec_core.sv
// tb_fuzz_exec_core: directed programs checked against an ISA-level interpreter of the core.
module tb_fuzz_exec_core;
  localparam int TO = 100;
  logic clk = 0, rst_n = 0, imem_we = 0, start = 0;
  logic [7:0] imem_addr = 0;
  logic [31:0] imem_wdata = 0;
  logic busy, done, halted_ok, timeout;
  logic [255:0] final_hash;
  logic [63:0] mu_total, mu_discovery, mu_execution;
  logic [31:0] step_count, num_modules, pc_out;
`ifdef FUZZ_CORE_TRACE_EN
  logic trace_valid;
  logic [63:0] trace_data;
`endif
  always #5 clk = ~clk;
  fuzz_exec_core #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .start(start), .busy(busy), .done(done), .halted_ok(halted_ok), .timeout(timeout),
    .final_hash(final_hash), .mu_total(mu_total), .mu_discovery(mu_discovery),
    .mu_execution(mu_execution), .step_count(step_count), .num_modules(num_modules), .pc_out(pc_out)
`ifdef FUZZ_CORE_TRACE_EN
    , .trace_valid(trace_valid), .trace_data(trace_data)
`endif
  );
  typedef struct {
    logic halted, to;
    logic [255:0] hash;
    logic [63:0] mt, md, me;
    logic [31:0] step, nmod, pc;
    int lat;
  } exp_t;
  logic [31:0] prog [256];
  exp_t e;
  int passed = 0, total = 0;
  logic check_en = 0, in_run = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [31:0] mix(input logic [31:0] v);
    logic [31:0] x;
    x = v ^ (v << 13);
    x = x ^ (x >> 17);
    return x ^ (x << 5);
  endfunction
  function automatic exp_t model();
    exp_t r;
    logic [31:0] d [16];
    logic [63:0] m [64];
    logic [31:0] w [8];
    logic [31:0] pc = 0, step = 0, ins, tmp;
    logic [63:0] md = 0, me = 0, mt = 0;
    logic [7:0] op, a, b;
    int nm = 0, icnt = 0, lat = 0;
    for (int i = 0; i < 16; i++) d[i] = 0;
    for (int i = 0; i < 64; i++) m[i] = 0;
    r.halted = 0; r.to = 0; r.hash = 0;
    for (int g = 0; g < 100000; g++) begin
      ins = prog[pc % 256];
      op = ins[31:24]; a = ins[23:16]; b = ins[15:8];
      if (op == 8'hFF) begin
        mt = md + me;
        lat += 10;
        r.halted = 1;
        w[0] = pc ^ nm; w[1] = nm ^ step; w[2] = md[31:0] ^ me[31:0]; w[3] = mt[31:0];
        w[4] = m[0][31:0]; w[5] = m[1][31:0]; w[6] = d[0]; w[7] = d[1];
        for (int i = 0; i < 8; i++) r.hash[i*32 +: 32] = mix(w[i]);
        break;
      end
      if (op == 8'h00 && nm < 64) begin
        m[nm] = 64'd1 << (a % 64);
        nm++;
        md++;
      end
      if (op == 8'h0A) begin d[a % 16] = b; me++; end
      if (op == 8'h0B) begin d[a % 16] ^= d[b % 16]; me++; end
      if (op == 8'h0C) begin
        if (a % 16 == b % 16) d[a % 16] = 0;
        else begin tmp = d[a % 16]; d[a % 16] = d[b % 16]; d[b % 16] = tmp; end
        me += 3;
        lat += 2;
      end
      pc++; step++; icnt++; lat += 2;
      if (icnt == TO) begin r.to = 1; break; end
    end
    r.mt = mt; r.md = md; r.me = me; r.step = step; r.nmod = nm; r.pc = pc; r.lat = lat;
    return r;
  endfunction
  always @(negedge clk) begin
    if (in_run && !done) chk("busy_in_run", busy, 1);
    if (check_en) begin
      chk("done", done, 1); chk("busy_after", busy, 0);
      chk("halted_ok", halted_ok, e.halted); chk("timeout", timeout, e.to);
      chk("final_hash", final_hash, e.hash); chk("mu_total", mu_total, e.mt);
      chk("mu_discovery", mu_discovery, e.md); chk("mu_execution", mu_execution, e.me);
      chk("step_count", step_count, e.step); chk("num_modules", num_modules, e.nmod);
      chk("pc_out", pc_out, e.pc);
    end
  end
  task automatic wr(input int addr, input logic [31:0] w);
    @(negedge clk);
    imem_we = 1; imem_addr = 8'(addr); imem_wdata = w; prog[addr] = w;
    @(negedge clk);
    imem_we = 0;
  endtask
  task automatic run(input bit poke);
    int cyc = 0;
    check_en = 0;
    e = model();
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0; in_run = 1;
    while (!done && cyc < 3000) begin
      @(posedge clk); cyc++;
      #1 start = poke && cyc == 3;
    end
    start = 0; in_run = 0;
    chk("latency", cyc, e.lat);
    check_en = 1;
    repeat (2) @(posedge clk);
  endtask
  task automatic zero_checks(input string tag);
    chk({tag, "_busy"}, busy, 0); chk({tag, "_done"}, done, 0);
    chk({tag, "_halted"}, halted_ok, 0); chk({tag, "_hash"}, final_hash, 0);
    chk({tag, "_pc"}, pc_out, 0); chk({tag, "_step"}, step_count, 0);
    chk({tag, "_mu"}, {mu_total, mu_discovery, mu_execution}, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 zero_checks("reset");
    rst_n = 1;
    for (int i = 0; i < 256; i++) wr(i, 0);
    wr(0, 32'hFF000000);
    run(0);
    chk("halt_only_hash", final_hash, 0);
    chk("halt_only_lat", e.lat, 10);
    wr(0, 32'h0A000500); wr(1, 32'h0A010300); wr(2, 32'h0B000100); wr(3, 32'hFF000000);
    run(0);
    chk("add_w0", final_hash[31:0], 32'h000C6063);
    chk("add_w7_d1", final_hash[255:224], 32'h000C6063);
    chk("add_mu_exec", mu_execution, 3);
    wr(2, 32'h0C000100);
    run(1);
    chk("swap_w6_d0", final_hash[223:192], 32'h000C6063);
    chk("swap_mu_exec", mu_execution, 5);
    chk("swap_lat", e.lat, 18);
    for (int i = 0; i < 65; i++) wr(i, {8'h00, 8'(i), 16'h0});
    wr(65, 32'hFF000000);
    run(0);
    chk("pnew_nmod", num_modules, 64); chk("pnew_md", mu_discovery, 64);
    chk("pnew_step", step_count, 65); chk("pnew_mask0", final_hash[159:128], 32'h00042021);
    wr(0, 32'h0A010700); wr(1, 32'h0C010100); wr(2, 32'h0E000000); wr(3, 32'h55000000);
    wr(4, 32'hFF000000);
    run(0);
    chk("self_swap_d1", final_hash[255:224], 0);
    chk("self_swap_step", step_count, 4);
    for (int i = 0; i < 256; i++) wr(i, 0);
    run(0);
    chk("to_flag", timeout, 1); chk("to_step", step_count, 100);
    chk("to_hash", final_hash, 0); chk("to_halted", halted_ok, 0);
    wr(0, 32'h0A000500); wr(1, 32'h0A010300); wr(2, 32'h0B000100); wr(3, 32'hFF000000);
    check_en = 0;
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    repeat (11) @(posedge clk);
    #1 chk("mid_hash_busy", busy, 1);
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1 zero_checks("abort");
    rst_n = 1;
    run(0);
    chk("rerun_w0", final_hash[31:0], 32'h000C6063);
    check_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fuzz_exec_core.md
Name: fuzz_exec_core

Overview:
Synthesisable, parametrised execution core for adversarial isomorphism fuzzing of the Python VM against RTL. It loads a program through a write port and runs the basic ISA subset (PNEW, XOR_LOAD/ADD/SWAP, EMIT, HALT) under a multi-cycle FSM with μ-cost accounting. On HALT it computes the 256-bit state hash sequentially and reports results through a start/done handshake. It sits under the fuzz bench as the DUT, replacing purely behavioural execution.

Parameters:
IMEM_AW, 8, instruction memory address width (depth 2^IMEM_AW, 32-bit words)
DMEM_AW, 4, data register-file address width (depth 2^DMEM_AW, 32-bit words)
MAX_MODULES, 64, module table capacity
MASK_W, 64, partition mask width (power of 2)
MU_W, 64, width of μ counters
TIMEOUT, 10000, instruction budget before timeout abort

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_we  in  1  instruction write strobe; ignored while busy
imem_addr  in  IMEM_AW  instruction write address
imem_wdata  in  32  instruction word {opcode[31:24], a[23:16], b[15:8], unused[7:0]}
start  in  1  start-run pulse; accepted only in IDLE or DONE
busy  out  1  run in progress
done  out  1  high in DONE until next accepted start
halted_ok  out  1  run ended by HALT
timeout  out  1  run ended by instruction budget
final_hash  out  256  state hash; valid when done && halted_ok
mu_total, mu_discovery, mu_execution  out  MU_W  μ counters
step_count  out  32  retired non-HALT instructions
num_modules  out  32  modules created
pc_out  out  32  program counter

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE; all outputs, counters, pc, module table, masks and data file are 0. Instruction memory is not reset.
- Accepted start clears pc, counters, module table, masks, data file, hash, halted_ok and timeout, then enters FETCH with busy=1 and done=0.
- FSM: IDLE -> FETCH (1 cycle, registered imem read at pc[IMEM_AW-1:0]) -> EXEC -> FETCH | SWAP2 | HASH | DONE.
- Each instruction takes 2 cycles; XOR_SWAP takes 4 cycles (EXEC, SWAP2, SWAP3 each perform one XOR write).
- Opcode behaviour (a, b are truncated to DMEM_AW for data access):
  - PNEW 0x00: if num_modules<MAX_MODULES, mask[num_modules]=1<<(a mod MASK_W), next_id+1, num_modules+1, mu_discovery+1; otherwise no table or μ change.
  - XOR_LOAD 0x0A: d[a]=zero-extended b; mu_execution+1.
  - XOR_ADD 0x0B: d[a]^=d[b]; mu_execution+1.
  - XOR_SWAP 0x0C: three XOR steps; mu_execution+3. When a==b the location becomes 0 (defined behaviour, matches the golden model).
  - EMIT 0x0E and any unknown opcode: no state change.
- Every opcode except HALT: pc+1 (32-bit, no wrap check; imem index wraps modulo depth) and step_count+1.
- HALT 0xFF: pc and step_count unchanged; mu_total=mu_discovery+mu_execution; halted_ok=1; go to HASH.
- Budget: an instruction counter increments at every non-HALT EXEC. When it reaches TIMEOUT, set timeout=1 and go to DONE; hash stays 0.
- HASH, 8 cycles, word i per cycle, written to final_hash[i*32+:32]:
  - w0=pc^next_id; w1=num_modules^step_count; w2=mu_disc[31:0]^mu_exec[31:0]; w3=mu_total[31:0]; w4=mask0[31:0]; w5=mask1[31:0]; w6=d[0]; w7=d[1].
  - Each word is mixed as x^=x<<13; x^=x>>17; x^=x<<5 (32-bit truncation).
- HASH -> DONE: busy=0, done=1. Outputs hold until the next start or reset.
- start while busy is ignored. Reset mid-run aborts immediately to the reset state.

Optional Feature:
FUZZ_CORE_TRACE_EN: adds output trace_valid (1 cycle per retired instruction, including HALT) and trace_data[63:0]={pc[15:0], opcode, a, b, step_count[15:0], 8'h0}. Without the macro these ports do not exist and there is no trace logic.

Test Plan:
- Imem[0]=FF000000, start -> after 2+8 cycles done=1, halted_ok=1, final_hash=0, mu_total=0, step_count=0.
- 0A000500, 0A010300, 0B000100, FF000000 -> d0=6, d1=3, mu_execution=3, mu_total=3, step_count=3, pc=3.
- 0A000500, 0A010300, 0C000100, FF000000 -> d0=3, d1=5, mu_execution=5, swap occupies 4 cycles.
- 65× PNEW a=0..64 then HALT -> num_modules=64, mu_discovery=64, step_count=65, mask0=1, mask1=2.
- TIMEOUT=100, imem all zero -> timeout=1, halted_ok=0, done=1, step_count=100, final_hash=0.
- rst_n low during HASH -> next cycle: busy=0, done=0, all outputs 0; rerun gives the same hash as an uninterrupted run.
